// File: rtl/qcw_pkg.sv
// Shared types and widths for the QCW burst sequencer slice.
package qcw_pkg;

  localparam int unsigned QCW_PHASE_W = 8;
  localparam int unsigned QCW_CYC_W   = 16;
  localparam int unsigned QCW_TMR_W   = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StRamp,
    StCooldown,
    StFault
  } qcw_state_e;

endpackage

// File: rtl/qcw_ramp_sequencer_if.sv
// Sequencer <-> qcw_driver control bus; master is the sequencer side.
interface qcw_ramp_sequencer_if;

  logic                                drv_start;
  logic                                drv_halt;
  logic [qcw_pkg::QCW_PHASE_W-1:0]     drv_phase_shift;
  logic [qcw_pkg::QCW_CYC_W-1:0]       drv_cycle_limit;
  logic                                drv_ready;
  logic                                drv_cycle_finished;
  logic                                drv_fault;

  modport master (
    output drv_start,
    output drv_halt,
    output drv_phase_shift,
    output drv_cycle_limit,
    input  drv_ready,
    input  drv_cycle_finished,
    input  drv_fault
  );

  modport slave (
    input  drv_start,
    input  drv_halt,
    input  drv_phase_shift,
    input  drv_cycle_limit,
    output drv_ready,
    output drv_cycle_finished,
    output drv_fault
  );

endinterface

// File: rtl/qcw_phase_ramp.sv
// Phase ramp: clock divider plus saturating up/down stepper toward a latched end value.
module qcw_phase_ramp import qcw_pkg::*; #(
  parameter int unsigned RAMP_STEP_DIV = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   en,
  input  logic [QCW_PHASE_W-1:0] start_val,
  input  logic [QCW_PHASE_W-1:0] end_val,
  input  logic [QCW_PHASE_W-1:0] step_val,
  output logic [QCW_PHASE_W-1:0] phase
);

  localparam logic [QCW_TMR_W-1:0] DivLast = QCW_TMR_W'(RAMP_STEP_DIV - 1);

  logic [QCW_PHASE_W-1:0] phase_q, phase_d;
  logic [QCW_PHASE_W-1:0] end_q, end_d;
  logic [QCW_PHASE_W-1:0] step_q, step_d;
  logic                   down_q, down_d;
  logic [QCW_TMR_W-1:0]   div_q, div_d;
  logic [QCW_PHASE_W:0]   sum, diff;
  logic                   step_now;

  always_comb begin
    phase_d  = phase_q;
    end_d    = end_q;
    step_d   = step_q;
    down_d   = down_q;
    div_d    = div_q;
    step_now = 1'b0;
    // 9-bit arithmetic: the carry/borrow bit flags overshoot past 0 or 255
    sum      = {1'b0, phase_q} + {1'b0, step_q};
    diff     = {1'b0, phase_q} - {1'b0, step_q};
    if (load) begin
      phase_d = start_val;
      end_d   = end_val;
      step_d  = step_val;
      down_d  = start_val > end_val;
      div_d   = '0;
    end else if (en) begin
      if (div_q >= DivLast) begin
        div_d    = '0;
        step_now = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
      if (step_now) begin
        if (down_q) begin
          phase_d = (diff[QCW_PHASE_W] || (diff[QCW_PHASE_W-1:0] <= end_q)) ?
                    end_q : diff[QCW_PHASE_W-1:0];
        end else begin
          phase_d = (sum >= {1'b0, end_q}) ? end_q : sum[QCW_PHASE_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      down_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      phase_q <= phase_d;
      end_q   <= end_d;
      step_q  <= step_d;
      down_q  <= down_d;
      div_q   <= div_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/qcw_ramp_sequencer.sv
// Burst-level controller for qcw_driver: launch, phase ramp, watchdog, cooldown, fault latch.
module qcw_ramp_sequencer import qcw_pkg::*; #(
  parameter int unsigned RAMP_STEP_DIV = 256,
  parameter int unsigned MIN_OFF_CLKS  = 1000000,
  parameter int unsigned WATCHDOG_CLKS = 2000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     fire_req,
  input  logic [QCW_PHASE_W-1:0]   phase_start,
  input  logic [QCW_PHASE_W-1:0]   phase_end,
  input  logic [QCW_PHASE_W-1:0]   ramp_step,
  input  logic [QCW_CYC_W-1:0]     burst_cycles,
  input  logic                     fault_clear,
  output logic                     busy,
  output logic                     done,
  output logic                     fault_latched,
  qcw_ramp_sequencer_if.master     drv
);

  localparam logic [QCW_TMR_W-1:0] WdLast  = QCW_TMR_W'(WATCHDOG_CLKS - 1);
  localparam logic [QCW_TMR_W-1:0] OffLast = QCW_TMR_W'(MIN_OFF_CLKS - 1);

  qcw_state_e state_q, state_d;
  logic [QCW_TMR_W-1:0] timer_q, timer_d;
  logic launch_go, burst_done, burst_abort, ramp_en;

  logic                 start_q, start_d;
  logic                 halt_q, halt_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 fault_q, fault_d;
  logic [QCW_CYC_W-1:0] limit_q, limit_d;

  // State and shared watchdog/cooldown timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    launch_go   = 1'b0;
    burst_done  = 1'b0;
    burst_abort = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arm && fire_req && drv.drv_ready) begin
          state_d   = StLaunch;
          launch_go = 1'b1;
        end
      end
      StLaunch: state_d = StRamp;
      StRamp: begin
        if (drv.drv_fault || (timer_q >= WdLast)) begin
          state_d = StFault;
        end else if (drv.drv_cycle_finished) begin
          state_d    = StCooldown;
          burst_done = 1'b1;
        end else if (!arm) begin
          state_d     = StCooldown;
          burst_abort = 1'b1;
        end
      end
      StCooldown: begin
        if (drv.drv_fault) begin
          state_d = StFault;
        end else if (timer_q >= OffLast) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        if (fault_clear && !drv.drv_fault) begin
          state_d = StCooldown;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timer restarts on entry to LAUNCH or COOLDOWN; LAUNCH->RAMP keeps counting
    if ((state_d != state_q) && (state_d != StRamp)) begin
      timer_d = '0;
    end else if (state_q inside {StLaunch, StRamp, StCooldown}) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = '0;
    end
  end

  always_comb begin
    start_d = (state_d == StLaunch);
    halt_d  = (state_d == StFault) || burst_abort;
    done_d  = burst_done;
    busy_d  = state_d inside {StLaunch, StRamp, StCooldown};
    fault_d = (state_d == StFault);
    limit_d = launch_go ? burst_cycles : limit_q;
    // Phase freezes on the edge that leaves RAMP
    ramp_en = (state_q == StLaunch) || ((state_q == StRamp) && (state_d == StRamp));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      halt_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      limit_q <= '0;
    end else begin
      start_q <= start_d;
      halt_q  <= halt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      limit_q <= limit_d;
    end
  end

  qcw_phase_ramp #(
    .RAMP_STEP_DIV (RAMP_STEP_DIV)
  ) u_phase_ramp (
    .clk       (clk),
    .rst       (rst),
    .load      (launch_go),
    .en        (ramp_en),
    .start_val (phase_start),
    .end_val   (phase_end),
    .step_val  (ramp_step),
    .phase     (drv.drv_phase_shift)
  );

  assign drv.drv_start       = start_q;
  assign drv.drv_halt        = halt_q;
  assign drv.drv_cycle_limit = limit_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign fault_latched       = fault_q;

endmodule

// File: tb/tb_qcw_ramp_sequencer.sv
// Directed + randomized bench for qcw_ramp_sequencer against a closed-form burst model.
module tb_qcw_ramp_sequencer;

  localparam int DIV = 4;
  localparam int MIN_OFF = 50;
  localparam int WD = 1000;

  localparam int M_IDLE = 0;
  localparam int M_LAUNCH = 1;
  localparam int M_RAMP = 2;
  localparam int M_COOL = 3;
  localparam int M_FAULT = 4;

  logic clk;
  logic rst, arm, fire_req, fault_clear;
  logic [7:0] phase_start, phase_end, ramp_step;
  logic [15:0] burst_cycles;
  logic busy, done, fault_latched;

  qcw_ramp_sequencer_if drv_bus ();

  qcw_ramp_sequencer #(
    .RAMP_STEP_DIV (DIV),
    .MIN_OFF_CLKS  (MIN_OFF),
    .WATCHDOG_CLKS (WD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .arm           (arm),
    .fire_req      (fire_req),
    .phase_start   (phase_start),
    .phase_end     (phase_end),
    .ramp_step     (ramp_step),
    .burst_cycles  (burst_cycles),
    .fault_clear   (fault_clear),
    .busy          (busy),
    .done          (done),
    .fault_latched (fault_latched),
    .drv           (drv_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: burst timeline with phase as a closed-form function of elapsed clocks
  bit model_valid = 1'b0;
  int mode, t_since_launch, t_cool;
  int m_start, m_end, m_step;
  int e_phase, e_limit;
  bit e_start, e_halt, e_done, e_busy, e_fault, abort_p;

  function automatic int ramp_val(input int k);
    int n;
    int v;
    n = k / DIV;
    if (m_start > m_end) begin
      v = m_start - n * m_step;
      if (v <= m_end) v = m_end;
    end else begin
      v = m_start + n * m_step;
      if (v >= m_end) v = m_end;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    model_valid = 1'b1;
    e_start = 1'b0;
    e_done = 1'b0;
    abort_p = 1'b0;
    if (rst) begin
      mode = M_IDLE;
      e_phase = 0;
      e_limit = 0;
      e_halt = 1'b1;
      e_busy = 1'b0;
      e_fault = 1'b0;
    end else begin
      case (mode)
        M_IDLE: begin
          if (arm && fire_req && drv_bus.drv_ready) begin
            mode = M_LAUNCH;
            m_start = int'(phase_start);
            m_end = int'(phase_end);
            m_step = int'(ramp_step);
            e_phase = m_start;
            e_limit = int'(burst_cycles);
            e_start = 1'b1;
            t_since_launch = 0;
          end
        end
        M_LAUNCH: begin
          mode = M_RAMP;
          t_since_launch = 1;
          e_phase = ramp_val(1);
        end
        M_RAMP: begin
          if (drv_bus.drv_fault || (t_since_launch + 1 >= WD)) begin
            mode = M_FAULT;
          end else if (drv_bus.drv_cycle_finished) begin
            mode = M_COOL;
            t_cool = 0;
            e_done = 1'b1;
          end else if (!arm) begin
            mode = M_COOL;
            t_cool = 0;
            abort_p = 1'b1;
          end else begin
            t_since_launch++;
            e_phase = ramp_val(t_since_launch);
          end
        end
        M_COOL: begin
          if (drv_bus.drv_fault) mode = M_FAULT;
          else if (t_cool + 1 >= MIN_OFF) mode = M_IDLE;
          else t_cool++;
        end
        default: begin
          if (fault_clear && !drv_bus.drv_fault) begin
            mode = M_COOL;
            t_cool = 0;
          end
        end
      endcase
      e_halt = (mode == M_FAULT) || abort_p;
      e_fault = (mode == M_FAULT);
      e_busy = (mode == M_LAUNCH) || (mode == M_RAMP) || (mode == M_COOL);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cmp_start", 32'(drv_bus.drv_start), 32'(e_start));
      check("cmp_halt", 32'(drv_bus.drv_halt), 32'(e_halt));
      check("cmp_phase", 32'(drv_bus.drv_phase_shift), 32'(e_phase));
      check("cmp_limit", 32'(drv_bus.drv_cycle_limit), 32'(e_limit));
      check("cmp_done", 32'(done), 32'(e_done));
      check("cmp_busy", 32'(busy), 32'(e_busy));
      check("cmp_fault", 32'(fault_latched), 32'(e_fault));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fire_once();
    fire_req = 1'b1;
    tick();
    fire_req = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; arm = 1'b0; fire_req = 1'b0; fault_clear = 1'b0;
    phase_start = '0; phase_end = '0; ramp_step = '0; burst_cycles = '0;
    drv_bus.drv_ready = 1'b1;
    drv_bus.drv_cycle_finished = 1'b0;
    drv_bus.drv_fault = 1'b0;

    repeat (3) tick();
    check("rst_halt", 32'(drv_bus.drv_halt), 32'd1);
    check("rst_phase", 32'(drv_bus.drv_phase_shift), 32'd0);
    check("rst_limit", 32'(drv_bus.drv_cycle_limit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_release_halt", 32'(drv_bus.drv_halt), 32'd0);

    // Up-ramp 100 -> 200 by 10 every 4 clocks
    arm = 1'b1; phase_start = 8'd100; phase_end = 8'd200; ramp_step = 8'd10;
    burst_cycles = 16'd1234;
    fire_once();
    check("launch_start", 32'(drv_bus.drv_start), 32'd1);
    check("launch_phase", 32'(drv_bus.drv_phase_shift), 32'd100);
    check("launch_limit", 32'(drv_bus.drv_cycle_limit), 32'd1234);
    tick();
    check("start_one_cycle", 32'(drv_bus.drv_start), 32'd0);
    repeat (2) tick();
    check("up_before_step", 32'(drv_bus.drv_phase_shift), 32'd100);
    tick();
    check("up_first_step", 32'(drv_bus.drv_phase_shift), 32'd110);
    repeat (32) tick();
    check("up_step9", 32'(drv_bus.drv_phase_shift), 32'd190);
    repeat (4) tick();
    check("up_reach_end", 32'(drv_bus.drv_phase_shift), 32'd200);
    repeat (8) tick();
    check("up_hold_end", 32'(drv_bus.drv_phase_shift), 32'd200);
    drv_bus.drv_cycle_finished = 1'b1;
    tick();
    drv_bus.drv_cycle_finished = 1'b0;
    check("done_pulse", 32'(done), 32'd1);
    check("done_no_halt", 32'(drv_bus.drv_halt), 32'd0);

    // Cooldown with fire held: relaunch exactly MIN_OFF+1 clocks after done
    phase_start = 8'd200; phase_end = 8'd50; ramp_step = 8'd60;
    fire_req = 1'b1;
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    n = 1;
    while (!drv_bus.drv_start && n < 200) begin
      tick();
      n++;
    end
    fire_req = 1'b0;
    check("relaunch_gap", 32'(n), 32'(MIN_OFF + 1));
    check("down_launch", 32'(drv_bus.drv_phase_shift), 32'd200);
    repeat (4) tick();
    check("down_1", 32'(drv_bus.drv_phase_shift), 32'd140);
    repeat (4) tick();
    check("down_2", 32'(drv_bus.drv_phase_shift), 32'd80);
    repeat (4) tick();
    check("down_sat", 32'(drv_bus.drv_phase_shift), 32'd50);
    repeat (8) tick();
    check("down_hold", 32'(drv_bus.drv_phase_shift), 32'd50);

    // Arm drop aborts with a single halt pulse
    arm = 1'b0;
    tick();
    arm = 1'b1;
    check("abort_halt", 32'(drv_bus.drv_halt), 32'd1);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    tick();
    check("abort_halt_pulse", 32'(drv_bus.drv_halt), 32'd0);
    fire_req = 1'b1;
    tick();
    fire_req = 1'b0;
    n = drv_bus.drv_start ? 1 : 0;
    repeat (60) begin
      tick();
      if (drv_bus.drv_start) n++;
    end
    check("cooldown_fire_dropped", 32'(n), 32'd0);
    check("back_idle", 32'(busy), 32'd0);

    // Fault mid-ramp, clear ignored while fault is high
    phase_start = 8'd10; phase_end = 8'd250; ramp_step = 8'd5;
    fire_once();
    repeat (5) tick();
    drv_bus.drv_fault = 1'b1;
    tick();
    check("fault_halt", 32'(drv_bus.drv_halt), 32'd1);
    check("fault_latched", 32'(fault_latched), 32'd1);
    check("fault_not_busy", 32'(busy), 32'd0);
    fire_once();
    check("fault_fire_ignored", 32'(drv_bus.drv_start), 32'd0);
    fault_clear = 1'b1;
    tick();
    check("clear_ignored", 32'(fault_latched), 32'd1);
    drv_bus.drv_fault = 1'b0;
    tick();
    fault_clear = 1'b0;
    check("clear_taken", 32'(fault_latched), 32'd0);
    check("clear_cooldown", 32'(busy), 32'd1);
    check("clear_halt_off", 32'(drv_bus.drv_halt), 32'd0);
    repeat (50) tick();
    check("fault_cooldown_idle", 32'(busy), 32'd0);

    // Watchdog with no cycle_finished
    fire_once();
    n = 0;
    while (!fault_latched && n < 1100) begin
      tick();
      n++;
    end
    check("watchdog_latency", 32'(n), 32'(WD));
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    repeat (50) tick();

    // Fault and finished together: fault wins, no done
    fire_once();
    repeat (3) tick();
    drv_bus.drv_fault = 1'b1;
    drv_bus.drv_cycle_finished = 1'b1;
    tick();
    drv_bus.drv_fault = 1'b0;
    drv_bus.drv_cycle_finished = 1'b0;
    check("simul_fault", 32'(fault_latched), 32'd1);
    check("simul_no_done", 32'(done), 32'd0);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    repeat (50) tick();

    // Reset mid-ramp
    fire_once();
    repeat (6) tick();
    rst = 1'b1;
    tick();
    check("rstmid_halt", 32'(drv_bus.drv_halt), 32'd1);
    check("rstmid_phase", 32'(drv_bus.drv_phase_shift), 32'd0);
    check("rstmid_limit", 32'(drv_bus.drv_cycle_limit), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Randomized traffic
    repeat (20000) begin
      rst = ($urandom_range(2999) == 0);
      arm = ($urandom_range(59) != 0);
      fire_req = ($urandom_range(3) == 0);
      fault_clear = ($urandom_range(19) == 0);
      drv_bus.drv_ready = ($urandom_range(7) != 0);
      drv_bus.drv_cycle_finished = ($urandom_range(39) == 0);
      drv_bus.drv_fault = ($urandom_range(299) == 0);
      phase_start = 8'($urandom);
      phase_end = 8'($urandom);
      ramp_step = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(80));
      burst_cycles = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
